// File: rtl/display_frame_scheduler_if.sv
// display_frame_scheduler_if: valid/ready bin stream from the spectrum source into the frame scheduler.
interface display_frame_scheduler_if;
    logic        bin_valid;
    logic        bin_ready;
    logic [2:0]  bin_idx;
    logic [11:0] bin_data;
    logic        bin_last;
    modport master (output bin_valid, bin_idx, bin_data, bin_last, input bin_ready);
    modport slave  (input bin_valid, bin_idx, bin_data, bin_last, output bin_ready);
endinterface

// File: rtl/display_frame_scheduler.sv
// display_frame_scheduler: assembles 8-band frames into a shadow buffer, commits them atomically,
// and manages display mode (button/auto timer) plus a stale-frame blanking watchdog.
module display_frame_scheduler #(
    parameter logic [23:0] AUTO_PERIOD   = 24'd5_000_000,
    parameter logic [23:0] STALE_TIMEOUT = 24'd1_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    display_frame_scheduler_if.slave   bin,
    input  logic                       btn_next,
    input  logic                       auto_en,
    output logic [95:0]                spectrum_data_packed,
    output logic [2:0]                 mode,
    output logic                       frame_update,
    output logic                       frame_err,
    output logic                       stale
);
    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;
    state_t            state_q, state_d;
    logic [2:0]        exp_q, exp_d;
    logic [7:0][11:0]  shadow_q, shadow_d;
    logic [95:0]       packed_q, packed_d;
    logic [2:0]        mode_q, mode_d, pend_q, pend_d;
    logic [23:0]       auto_q, auto_d, scnt_q, scnt_d;
    logic              stale_q, stale_d, upd_q, upd_d, err_q, err_d;
    logic              xfer, bad, done, commit, wrap, hit;

    assign xfer = bin.bin_valid & bin.bin_ready;
    // An index mismatch, or bin_last disagreeing with "this is band 7", aborts the frame
    assign bad  = xfer & ((bin.bin_idx != exp_q) | (bin.bin_last != (bin.bin_idx == 3'd7)));
    assign done = xfer & ~bad & bin.bin_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == COMMIT || bad) ? IDLE : done ? COMMIT : xfer ? FILL : state_q;
    end

    always_comb begin
        bin.bin_ready = ~rst & (state_q != COMMIT);
        commit        = state_q == COMMIT;
    end

    always_comb begin
        exp_d    = (bad || done) ? 3'd0 : xfer ? exp_q + 3'd1 : exp_q;
        shadow_d = shadow_q;
        if (xfer) shadow_d[bin.bin_idx] = bin.bin_data;
        if (bad) shadow_d = '0;
        wrap     = auto_en && auto_q == AUTO_PERIOD - 24'd1;
        auto_d   = (!auto_en || btn_next || wrap) ? 24'd0 : auto_q + 24'd1;
        // A button press on the wrap cycle still yields a single advance
        pend_d   = (btn_next || wrap) ? ((pend_q == 3'd2) ? 3'd0 : pend_q + 3'd1) : pend_q;
        scnt_d   = commit ? 24'd0 : (scnt_q == STALE_TIMEOUT) ? scnt_q : scnt_q + 24'd1;
        hit      = !commit && scnt_d == STALE_TIMEOUT;
        stale_d  = commit ? 1'b0 : stale_q | hit;
        packed_d = commit ? shadow_q : hit ? 96'd0 : packed_q;
        mode_d   = (commit || stale_q) ? pend_q : mode_q;
        upd_d    = commit;
        err_d    = bad;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q    <= '0;
            shadow_q <= '0;
            packed_q <= '0;
            mode_q   <= '0;
            pend_q   <= '0;
            auto_q   <= '0;
            scnt_q   <= '0;
            stale_q  <= 1'b0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            shadow_q <= shadow_d;
            packed_q <= packed_d;
            mode_q   <= mode_d;
            pend_q   <= pend_d;
            auto_q   <= auto_d;
            scnt_q   <= scnt_d;
            stale_q  <= stale_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign spectrum_data_packed = packed_q;
    assign mode                 = mode_q;
    assign frame_update         = upd_q;
    assign frame_err            = err_q;
    assign stale                = stale_q;
endmodule

// File: tb/tb_display_frame_scheduler.sv
// tb_display_frame_scheduler: directed sequence with a commit scoreboard and a small mode-timer model.
module tb_display_frame_scheduler;
    localparam logic [23:0] AP = 24'd4;
    localparam logic [23:0] ST = 24'd16;

    logic        clk = 1'b0, rst = 1'b1, btn_next = 1'b0, auto_en = 1'b0;
    logic [95:0] packed_o;
    logic [2:0]  mode;
    logic        frame_update, frame_err, stale;
    int          n_vec = 0, n_err = 0;

    display_frame_scheduler_if bif();

    display_frame_scheduler #(.AUTO_PERIOD(AP), .STALE_TIMEOUT(ST)) dut (
        .clk(clk), .rst(rst), .bin(bif.slave), .btn_next(btn_next), .auto_en(auto_en),
        .spectrum_data_packed(packed_o), .mode(mode), .frame_update(frame_update),
        .frame_err(frame_err), .stale(stale)
    );

    always #5 clk = ~clk;

    typedef struct { logic [95:0] pk; logic [2:0] md; } exp_t;
    exp_t sb[$];

    logic [23:0] m_tm;
    logic [2:0]  m_pm;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tm <= '0;
            m_pm <= '0;
        end else begin
            if (btn_next || (auto_en && m_tm == AP - 24'd1)) m_pm <= (m_pm == 3'd2) ? 3'd0 : m_pm + 3'd1;
            m_tm <= (!auto_en || btn_next || m_tm == AP - 24'd1) ? 24'd0 : m_tm + 24'd1;
        end
    end

    function automatic logic [2:0] nxt(logic [2:0] m);
        return (m == 3'd2) ? 3'd0 : m + 3'd1;
    endfunction

    task automatic chkw(string tag, logic [95:0] obs, logic [95:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chkb(string tag, logic obs, logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    logic [2:0] prev_mode = 3'd0;
    always @(negedge clk) begin
        if (!rst) begin
            n_vec++;
            assert (stale || frame_update || mode === prev_mode) else begin
                n_err++;
                $error("FAIL mode_hold observed=%0d expected=%0d", mode, prev_mode);
            end
            if (frame_update) begin
                chkb("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chkw("commit_packed", packed_o, e.pk);
                    chkw("commit_mode", 96'(mode), 96'(e.md));
                end
            end
        end
        prev_mode = mode;
    end

    task automatic send_frame(input logic [95:0] f);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chkb("ready", bif.bin_ready, 1'b1);
            chkb("no_err", frame_err, 1'b0);
            bif.bin_valid = 1'b1;
            bif.bin_idx   = k[2:0];
            bif.bin_data  = f[12*k +: 12];
            bif.bin_last  = (k == 7);
        end
        @(negedge clk);
        bif.bin_valid = 1'b0;
        bif.bin_last  = 1'b0;
        sb.push_back('{f, m_pm});
        chkb("lat_n1", frame_update, 1'b0);
        chkb("commit_not_ready", bif.bin_ready, 1'b0);
        chkb("no_err_last", frame_err, 1'b0);
        @(negedge clk);
        chkb("lat_n2", frame_update, 1'b1);
    endtask

    task automatic drive_bin(input logic [2:0] idx, input logic [11:0] d, input logic last);
        @(negedge clk);
        bif.bin_valid = 1'b1;
        bif.bin_idx   = idx;
        bif.bin_data  = d;
        bif.bin_last  = last;
    endtask

    task automatic check_all_zero(string tag);
        chkw({tag, "_packed"}, packed_o, 96'd0);
        chkw({tag, "_mode"}, 96'(mode), 96'd0);
        chkb({tag, "_upd"}, frame_update, 1'b0);
        chkb({tag, "_err"}, frame_err, 1'b0);
        chkb({tag, "_stale"}, stale, 1'b0);
        chkb({tag, "_ready"}, bif.bin_ready, 1'b0);
    endtask

    initial begin
        logic [95:0] fa, fb, fm, fr, fz;
        logic [2:0]  old;
        bif.bin_valid = 1'b0;
        bif.bin_idx   = '0;
        bif.bin_data  = '0;
        bif.bin_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        chkb("ready_after_rst", bif.bin_ready, 1'b1);

        for (int k = 0; k < 8; k++) fa[12*k +: 12] = 12'h100 * k[11:0] + 12'h001;
        send_frame(fa);
        chkw("frameA", packed_o, 96'h701601501401301201101001);

        drive_bin(3'd0, 12'hAAA, 1'b0);
        drive_bin(3'd1, 12'hBBB, 1'b0);
        drive_bin(3'd3, 12'hCCC, 1'b0);
        @(negedge clk);
        bif.bin_valid = 1'b0;
        chkb("err_pulse", frame_err, 1'b1);
        @(negedge clk);
        chkb("err_once", frame_err, 1'b0);
        chkb("err_no_upd", frame_update, 1'b0);
        chkw("err_keep_packed", packed_o, fa);

        fb = {$urandom, $urandom, $urandom};
        send_frame(fb);
        chkw("frameB", packed_o, fb);

        drive_bin(3'd0, 12'h123, 1'b1);
        @(negedge clk);
        bif.bin_valid = 1'b0;
        bif.bin_last  = 1'b0;
        chkb("err_early_last", frame_err, 1'b1);

        auto_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fm = {$urandom, $urandom, $urandom};
            send_frame(fm);
        end
        auto_en = 1'b0;

        repeat (15) @(negedge clk);
        chkb("stale_before", stale, 1'b0);
        chkw("packed_before_stale", packed_o, fm);
        @(negedge clk);
        chkb("stale_at_timeout", stale, 1'b1);
        chkw("packed_blanked", packed_o, 96'd0);
        @(negedge clk);
        chkw("stale_follow", 96'(mode), 96'(m_pm));

        old = m_pm;
        auto_en = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        auto_en  = 1'b0;
        @(negedge clk);
        chkw("btn_wrap_once", 96'(mode), 96'(nxt(old)));
        btn_next = 1'b1;
        @(negedge clk);
        btn_next = 1'b0;
        @(negedge clk);
        chkw("btn_advance", 96'(mode), 96'(nxt(nxt(old))));

        fr = {$urandom, $urandom, $urandom};
        send_frame(fr);
        chkb("stale_cleared", stale, 1'b0);
        chkw("frame_recover", packed_o, fr);

        for (int k = 0; k < 4; k++) drive_bin(k[2:0], 12'h0F0, 1'b0);
        @(negedge clk);
        bif.bin_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        fz = {$urandom, $urandom, $urandom};
        send_frame(fz);
        chkw("frame_after_rst", packed_o, fz);
        @(negedge clk);
        chkb("no_err_after_rst", frame_err, 1'b0);
        chkw("sb_drained", 96'(sb.size()), 96'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
